cplx_dot_acc: RTL and testbench

//  Complex dot-product accumulator for the 32x32 complex matrix multiply datapath.
//  - Sits directly downstream of the sumtwo stage and consumes its per-term complex product (ab_real/ab_imag, Q11.21).
//  - Accumulates NTERM consecutive valid terms into one matrix element, saturates the result to 32 bits.
//  - Emits a one-cycle write strobe with an element address that drives the result single-port RAMs.

---
 rtl/cplx_dot_acc_if.sv | 28 ++
 rtl/cplx_dot_acc.sv | 151 +++++++++++++++
 tb/tb_cplx_dot_acc.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cplx_dot_acc_if.sv
// Interface for the complex dot-product accumulator. It carries the term input
// stream and the result-RAM write port with its status flags.
interface cplx_dot_acc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  i_start;
    logic                  i_in_valid;
    logic [DATA_WIDTH-1:0] i_ab_real;
    logic [DATA_WIDTH-1:0] i_ab_imag;
    logic [DATA_WIDTH-1:0] o_out_real;
    logic [DATA_WIDTH-1:0] o_out_imag;
    logic [ADDR_WIDTH-1:0] o_out_addr;
    logic                  o_we;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_sat_flag;

    modport master (
        output i_start, i_in_valid, i_ab_real, i_ab_imag,
        input  o_out_real, o_out_imag, o_out_addr, o_we, o_busy, o_done, o_sat_flag
    );

    modport slave (
        input  i_start, i_in_valid, i_ab_real, i_ab_imag,
        output o_out_real, o_out_imag, o_out_addr, o_we, o_busy, o_done, o_sat_flag
    );
endinterface

// File: rtl/cplx_dot_acc.sv
// Complex dot-product accumulator. It sums NTERM Q11.21 terms per element and
// writes a saturated result for each element. A run ends after NELEM elements.
module cplx_dot_acc #(
    parameter int DATA_WIDTH = 32,
    parameter int NTERM      = 32,
    parameter int NELEM      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input logic           clk,
    input logic           rst,
    cplx_dot_acc_if.slave bus
);
    localparam int GUARD = $clog2(NTERM);
    localparam int ACC_W = DATA_WIDTH + GUARD;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2} state_t;

    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc_re, r_acc_im, w_acc_re_nxt, w_acc_im_nxt;
    logic signed [ACC_W-1:0] w_sum_re, w_sum_im;
    logic [GUARD-1:0]        r_term_cnt, w_term_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   r_elem_cnt, w_elem_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_out_re, r_out_im, w_out_re_nxt, w_out_im_nxt;
    logic [ADDR_WIDTH-1:0]   r_out_addr, w_out_addr_nxt;
    logic                    r_we, r_busy, r_done, r_sat;
    logic                    w_we_nxt, w_done_nxt, w_sat_nxt;
    logic [DATA_WIDTH:0]     w_sat_re, w_sat_im;
    logic                    w_last_term, w_last_elem;

    // Clamp to the signed DATA_WIDTH range when the guard bits disagree with the sign; the MSB of the result flags a clamp.
    function automatic logic [DATA_WIDTH:0] sat_word(input logic signed [ACC_W-1:0] v);
        logic [GUARD:0] top;
        top = v[ACC_W-1:DATA_WIDTH-1];
        if ((top == {(GUARD+1){1'b0}}) || (top == {(GUARD+1){1'b1}})) begin
            return {1'b0, v[DATA_WIDTH-1:0]};
        end else if (v[ACC_W-1]) begin
            return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    assign w_sum_re    = r_acc_re + {{GUARD{bus.i_ab_real[DATA_WIDTH-1]}}, bus.i_ab_real};
    assign w_sum_im    = r_acc_im + {{GUARD{bus.i_ab_imag[DATA_WIDTH-1]}}, bus.i_ab_imag};
    assign w_sat_re    = sat_word(w_sum_re);
    assign w_sat_im    = sat_word(w_sum_im);
    assign w_last_term = bus.i_in_valid && (r_term_cnt == GUARD'(NTERM - 1));
    assign w_last_elem = (r_elem_cnt == ADDR_WIDTH'(NELEM - 1));

    // Next-state and next-register-value logic for the IDLE/ACC/DONE control.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_re_nxt   = r_acc_re;
        w_acc_im_nxt   = r_acc_im;
        w_term_cnt_nxt = r_term_cnt;
        w_elem_cnt_nxt = r_elem_cnt;
        w_out_re_nxt   = r_out_re;
        w_out_im_nxt   = r_out_im;
        w_out_addr_nxt = r_out_addr;
        w_sat_nxt      = r_sat;
        w_we_nxt       = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt    = S_ACC;
                    w_acc_re_nxt   = {ACC_W{1'b0}};
                    w_acc_im_nxt   = {ACC_W{1'b0}};
                    w_term_cnt_nxt = {GUARD{1'b0}};
                    w_elem_cnt_nxt = {ADDR_WIDTH{1'b0}};
                    w_sat_nxt      = 1'b0;
                end else begin
                    w_state_nxt    = S_IDLE;
                end
            end
            S_ACC: begin
                if (w_last_term) begin
                    w_out_re_nxt   = w_sat_re[DATA_WIDTH-1:0];
                    w_out_im_nxt   = w_sat_im[DATA_WIDTH-1:0];
                    w_out_addr_nxt = r_elem_cnt;
                    w_we_nxt       = 1'b1;
                    w_sat_nxt      = r_sat | w_sat_re[DATA_WIDTH] | w_sat_im[DATA_WIDTH];
                    w_acc_re_nxt   = {ACC_W{1'b0}};
                    w_acc_im_nxt   = {ACC_W{1'b0}};
                    w_term_cnt_nxt = {GUARD{1'b0}};
                    w_elem_cnt_nxt = r_elem_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    w_state_nxt    = w_last_elem ? S_DONE : S_ACC;
                end else if (bus.i_in_valid) begin
                    w_acc_re_nxt   = w_sum_re;
                    w_acc_im_nxt   = w_sum_im;
                    w_term_cnt_nxt = r_term_cnt + {{(GUARD-1){1'b0}}, 1'b1};
                end else begin
                    w_state_nxt    = S_ACC;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_re   <= {ACC_W{1'b0}};
            r_acc_im   <= {ACC_W{1'b0}};
            r_term_cnt <= {GUARD{1'b0}};
            r_elem_cnt <= {ADDR_WIDTH{1'b0}};
            r_out_re   <= {DATA_WIDTH{1'b0}};
            r_out_im   <= {DATA_WIDTH{1'b0}};
            r_out_addr <= {ADDR_WIDTH{1'b0}};
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_acc_re   <= w_acc_re_nxt;
            r_acc_im   <= w_acc_im_nxt;
            r_term_cnt <= w_term_cnt_nxt;
            r_elem_cnt <= w_elem_cnt_nxt;
            r_out_re   <= w_out_re_nxt;
            r_out_im   <= w_out_im_nxt;
            r_out_addr <= w_out_addr_nxt;
            r_we       <= w_we_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_sat      <= w_sat_nxt;
        end
    end

    assign bus.o_out_real = r_out_re;
    assign bus.o_out_imag = r_out_im;
    assign bus.o_out_addr = r_out_addr;
    assign bus.o_we       = r_we;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_sat_flag = r_sat;
endmodule

// File: tb/tb_cplx_dot_acc.sv
// Directed bench for cplx_dot_acc with NTERM=4 and NELEM=2. A scoreboard queue
// holds the expected writes, which a negedge monitor pops and compares.
module tb_cplx_dot_acc;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NT = 4;
    localparam int NE = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    exp_t    q[$];
    longint  m_re, m_im;
    int      m_cnt, m_elem;
    bit      m_sat;
    logic [DW-1:0] m_last_re, m_last_im;

    cplx_dot_acc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cplx_dot_acc #(.DATA_WIDTH(DW), .NTERM(NT), .NELEM(NE), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] sat32(input longint s);
        if (s > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        else if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else return {1'b0, s[31:0]};
    endfunction

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && bus.o_we !== 1'b0) begin
            if (q.size() == 0) begin
                check("we_unexpected", {63'b0, bus.o_we}, 64'd0);
            end else begin
                e = q.pop_front();
                check("wr_addr", {54'b0, bus.o_out_addr}, {54'b0, e.addr});
                check("wr_real", {32'b0, bus.o_out_real}, {32'b0, e.re});
                check("wr_imag", {32'b0, bus.o_out_imag}, {32'b0, e.im});
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_re = 0; m_im = 0; m_cnt = 0; m_elem = 0;
    endtask

    task automatic do_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        model_clear();
        m_sat = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input int gap);
        logic [32:0] sr, si;
        exp_t e;
        bus.i_in_valid = 1'b1;
        bus.i_ab_real  = re;
        bus.i_ab_imag  = im;
        m_re += longint'($signed(re));
        m_im += longint'($signed(im));
        m_cnt++;
        if (m_cnt == NT) begin
            sr = sat32(m_re);
            si = sat32(m_im);
            m_sat = m_sat | sr[32] | si[32];
            e.addr = AW'(m_elem);
            e.re = sr[31:0];
            e.im = si[31:0];
            e.cyc = cyc + 1;
            q.push_back(e);
            m_last_re = sr[31:0];
            m_last_im = si[31:0];
            m_elem++;
            m_re = 0; m_im = 0; m_cnt = 0;
        end
        tick();
        bus.i_in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Called one cycle after the final write edge of a run.
    task automatic finish_run(input string tag);
        check({tag, "_busy_last_wr"}, {63'b0, bus.o_busy}, 64'd1);
        tick();
        check({tag, "_done_pulse"}, {63'b0, bus.o_done}, 64'd1);
        check({tag, "_we_low_done"}, {63'b0, bus.o_we}, 64'd0);
        tick();
        check({tag, "_done_clear"}, {63'b0, bus.o_done}, 64'd0);
        check({tag, "_busy_idle"}, {63'b0, bus.o_busy}, 64'd0);
        check({tag, "_hold_real"}, {32'b0, bus.o_out_real}, {32'b0, m_last_re});
        check({tag, "_sat_flag"}, {63'b0, bus.o_sat_flag}, {63'b0, m_sat});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_real"}, {32'b0, bus.o_out_real}, 64'd0);
        check({tag, "_imag"}, {32'b0, bus.o_out_imag}, 64'd0);
        check({tag, "_addr"}, {54'b0, bus.o_out_addr}, 64'd0);
        check({tag, "_ctrl"}, {60'b0, bus.o_we, bus.o_busy, bus.o_done, bus.o_sat_flag}, 64'd0);
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_in_valid = 1'b0;
        bus.i_ab_real = 32'h0;
        bus.i_ab_imag = 32'h0;
        model_clear();
        m_sat = 1'b0;
        m_last_re = 32'h0;
        m_last_im = 32'h0;
        #1;
        check_all_zero("reset");
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // In IDLE, valid terms without start are ignored.
        bus.i_in_valid = 1'b1;
        bus.i_ab_real = 32'h0030_0000;
        bus.i_ab_imag = 32'h0011_0000;
        repeat (3) tick();
        bus.i_in_valid = 1'b0;
        check("idle_busy", {63'b0, bus.o_busy}, 64'd0);

        // Back-to-back terms, then the same terms with gaps.
        do_start();
        check("start_busy", {63'b0, bus.o_busy}, 64'd1);
        repeat (4) send(32'h0020_0000, 32'hFFF0_0000, 0);
        check("t1_sat_flag", {63'b0, bus.o_sat_flag}, 64'd0);
        send(32'h0020_0000, 32'hFFF0_0000, 1);
        send(32'h0020_0000, 32'hFFF0_0000, 3);
        send(32'h0020_0000, 32'hFFF0_0000, 2);
        send(32'h0020_0000, 32'hFFF0_0000, 0);
        finish_run("t2");

        // Saturation of both parts. Then a start pulse mid-element.
        do_start();
        repeat (4) send(32'h7FFF_FFFF, 32'h8000_0000, 0);
        check("t3_sat_flag", {63'b0, bus.o_sat_flag}, 64'd1);
        send(32'h0020_0000, 32'h0000_1234, 0);
        send(32'hFFE0_0000, 32'h0040_0000, 0);
        bus.i_start = 1'b1;
        send(32'h0060_0000, 32'hFF00_0000, 0);
        bus.i_start = 1'b0;
        send(32'h0001_0001, 32'h0000_0007, 0);
        finish_run("t3");

        // Eight back-to-back terms of 1.0; sat_flag cleared at start.
        do_start();
        check("t4_sat_cleared", {63'b0, bus.o_sat_flag}, 64'd0);
        repeat (8) send(32'h0020_0000, 32'h0000_0000, 0);
        finish_run("t4");

        // Reset mid-element, then a fresh run with random terms.
        do_start();
        send(32'h0123_4567, 32'h0765_4321, 0);
        send(32'h0020_0000, 32'hFFF0_0000, 0);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        model_clear();
        m_sat = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        do_start();
        for (int i = 0; i < 2 * NT; i++) begin
            send($urandom(), $urandom(), 0);
        end
        finish_run("t5");

        repeat (2) tick();
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
